// File: rtl/wb_load_resp_stage.sv
// wb_load_resp_stage: writeback stage with a decoupled load-response channel.
// Early load responses are queued in a small FIFO, and WB stalls until the
// data for its load is available. The data is then aligned and extended for
// LW/LB/LBU/LH/LHU/LWL/LWR.
// Optional feature macro: WB_RESP_FWD_EN. When it is defined, a response that
// arrives while the FIFO is empty goes straight to a waiting load.
module wb_load_resp_stage #(
    parameter int RESP_DEPTH = 2,
    parameter int CNT_W      = $clog2(RESP_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_wb_valid,
    output logic        wb_allowin,
    output logic        wb_stage_valid,
    output logic        wb_stall,
    input  logic        mem_load_issue,
    output logic        load_credit,
    input  logic        data_rvalid,
    input  logic [31:0] data_rdata,
    output logic        resp_err,
    input  logic [3:0]  RegWrite_MEM_WB,
    input  logic [2:0]  LoadType_MEM_WB,
    input  logic        AltSel_MEM_WB,
    input  logic [31:0] AltData_MEM_WB,
    input  logic [4:0]  RegWaddr_MEM_WB,
    input  logic [31:0] ALUResult_MEM_WB,
    input  logic [31:0] RegRdata2_MEM_WB,
    input  logic [31:0] PC_MEM_WB,
    output logic [4:0]  RegWaddr_WB,
    output logic [31:0] RegWdata_WB,
    output logic [3:0]  RegWrite_WB,
    output logic [31:0] RegWdata_Bypass_WB,
    output logic [31:0] PC_WB
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    localparam logic [2:0] LT_LW  = 3'd1;
    localparam logic [2:0] LT_LB  = 3'd2;
    localparam logic [2:0] LT_LBU = 3'd3;
    localparam logic [2:0] LT_LH  = 3'd4;
    localparam logic [2:0] LT_LHU = 3'd5;
    localparam logic [2:0] LT_LWL = 3'd6;
    localparam logic [2:0] LT_LWR = 3'd7;

    // WB pipeline register
    logic        wb_valid_q;
    logic [3:0]  regwrite_q;
    logic [2:0]  loadtype_q;
    logic        altsel_q;
    logic [31:0] altdata_q;
    logic [4:0]  waddr_q;
    logic [31:0] alu_q;
    logic [31:0] rt_q;
    logic [31:0] pc_q;

    // Response FIFO and occupancy tracking
    logic [31:0]      fifo_mem_q [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic             resp_err_q, resp_err_d;

    logic        is_load;
    logic        fifo_empty;
    logic        fifo_full;
    logic        rsp_accept;
    logic        fwd_hit;
    logic        wb_ready_go;
    logic        wb_fire;
    logic        pop;
    logic        push_req;
    logic        overflow;
    logic        push;
    logic [CNT_W:0] inflight;
    logic [31:0] load_word;
    logic [31:0] aligned;
    logic [31:0] result;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign is_load    = (loadtype_q != 3'd0);
    assign fifo_empty = (fifo_count_q == '0);
    assign fifo_full  = (fifo_count_q == CNT_W'(RESP_DEPTH));
    // A response is only meaningful when a load is actually outstanding.
    assign rsp_accept = data_rvalid && (outstanding_q != '0);

`ifdef WB_RESP_FWD_EN
    assign fwd_hit = rsp_accept && fifo_empty && wb_valid_q && is_load;
`else
    assign fwd_hit = 1'b0;
`endif

    assign wb_ready_go = !is_load || !fifo_empty || fwd_hit;
    assign wb_fire     = wb_valid_q && wb_ready_go;
    assign wb_allowin  = !wb_valid_q || wb_ready_go;
    assign wb_stall    = wb_valid_q && !wb_ready_go;
    assign wb_stage_valid = wb_valid_q;

    assign pop      = wb_fire && is_load && !fwd_hit;
    assign push_req = rsp_accept && !fwd_hit;
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    assign overflow = push_req && fifo_full && !pop;
    assign push     = push_req && !overflow;

    assign inflight    = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    assign load_credit = (inflight < (CNT_W + 1)'(RESP_DEPTH));
    assign resp_err    = resp_err_q;

    // Next-state for FIFO pointers, occupancy, outstanding loads and error flag
    always_comb begin
        wr_ptr_d      = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d      = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_count_d  = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
        outstanding_d = outstanding_q + CNT_W'(mem_load_issue) - CNT_W'(rsp_accept);
        resp_err_d    = resp_err_q || (data_rvalid && (outstanding_q == '0)) || overflow;
    end

    // Control state registers; reset discards every in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            outstanding_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
            outstanding_q <= outstanding_d;
            resp_err_q    <= resp_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RESP_DEPTH; gi++) begin : g_fifo
            // Capture a response word into the slot addressed by the write pointer
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    fifo_mem_q[gi] <= data_rdata;
                end
            end
        end
    endgenerate

    // WB register: take the MEM fields whenever the stage accepts a new instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            regwrite_q <= '0;
            loadtype_q <= '0;
            altsel_q   <= 1'b0;
            altdata_q  <= '0;
            waddr_q    <= '0;
            alu_q      <= '0;
            rt_q       <= '0;
            pc_q       <= '0;
        end else if (wb_allowin) begin
            wb_valid_q <= mem_to_wb_valid;
            if (mem_to_wb_valid) begin
                regwrite_q <= RegWrite_MEM_WB;
                loadtype_q <= LoadType_MEM_WB;
                altsel_q   <= AltSel_MEM_WB;
                altdata_q  <= AltData_MEM_WB;
                waddr_q    <= RegWaddr_MEM_WB;
                alu_q      <= ALUResult_MEM_WB;
                rt_q       <= RegRdata2_MEM_WB;
                pc_q       <= PC_MEM_WB;
            end
        end
    end

    assign load_word = fwd_hit ? data_rdata : fifo_mem_q[rd_ptr_q];

    // Align and extend the load word by access type and low address bits
    always_comb begin
        aligned = load_word;
        case (loadtype_q)
            LT_LW: aligned = load_word;
            LT_LB, LT_LBU: begin
                case (alu_q[1:0])
                    2'd0: aligned = {24'd0, load_word[7:0]};
                    2'd1: aligned = {24'd0, load_word[15:8]};
                    2'd2: aligned = {24'd0, load_word[23:16]};
                    default: aligned = {24'd0, load_word[31:24]};
                endcase
                if (loadtype_q == LT_LB) begin
                    aligned[31:8] = {24{aligned[7]}};
                end
            end
            LT_LH, LT_LHU: begin
                aligned = alu_q[1] ? {16'd0, load_word[31:16]} : {16'd0, load_word[15:0]};
                if (loadtype_q == LT_LH) begin
                    aligned[31:16] = {16{aligned[15]}};
                end
            end
            LT_LWL: begin
                case (alu_q[1:0])
                    2'd0: aligned = {load_word[7:0],  rt_q[23:0]};
                    2'd1: aligned = {load_word[15:0], rt_q[15:0]};
                    2'd2: aligned = {load_word[23:0], rt_q[7:0]};
                    default: aligned = load_word;
                endcase
            end
            LT_LWR: begin
                case (alu_q[1:0])
                    2'd0: aligned = load_word;
                    2'd1: aligned = {rt_q[31:24], load_word[31:8]};
                    2'd2: aligned = {rt_q[31:16], load_word[31:16]};
                    default: aligned = {rt_q[31:8], load_word[31:24]};
                endcase
            end
            default: aligned = load_word;
        endcase
    end

    assign result = altsel_q ? altdata_q : (is_load ? aligned : alu_q);

    assign RegWrite_WB        = wb_fire ? regwrite_q : 4'd0;
    assign RegWaddr_WB        = wb_fire ? waddr_q    : 5'd0;
    assign RegWdata_WB        = wb_fire ? result     : 32'd0;
    assign RegWdata_Bypass_WB = result;
    assign PC_WB              = pc_q;

endmodule

// File: tb/tb_wb_load_resp_stage.sv
// Testbench for wb_load_resp_stage (default build, RESP_DEPTH=2): directed
// scenarios with known constants, then randomized traffic against a queue model.
module tb_wb_load_resp_stage;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        mem_to_wb_valid;
    logic        wb_allowin;
    logic        wb_stage_valid;
    logic        wb_stall;
    logic        mem_load_issue;
    logic        load_credit;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        resp_err;
    logic [3:0]  RegWrite_MEM_WB;
    logic [2:0]  LoadType_MEM_WB;
    logic        AltSel_MEM_WB;
    logic [31:0] AltData_MEM_WB;
    logic [4:0]  RegWaddr_MEM_WB;
    logic [31:0] ALUResult_MEM_WB;
    logic [31:0] RegRdata2_MEM_WB;
    logic [31:0] PC_MEM_WB;
    logic [4:0]  RegWaddr_WB;
    logic [31:0] RegWdata_WB;
    logic [3:0]  RegWrite_WB;
    logic [31:0] RegWdata_Bypass_WB;
    logic [31:0] PC_WB;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_valid;
    logic [3:0]  m_rw;
    logic [2:0]  m_lt;
    bit          m_alt;
    logic [31:0] m_altd;
    logic [4:0]  m_wa;
    logic [31:0] m_alu;
    logic [31:0] m_rt;
    logic [31:0] m_pc;
    logic [31:0] m_fifo[$];
    int          m_out;
    bit          m_err;

    wb_load_resp_stage #(.RESP_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .mem_to_wb_valid(mem_to_wb_valid),
        .wb_allowin(wb_allowin),
        .wb_stage_valid(wb_stage_valid),
        .wb_stall(wb_stall),
        .mem_load_issue(mem_load_issue),
        .load_credit(load_credit),
        .data_rvalid(data_rvalid),
        .data_rdata(data_rdata),
        .resp_err(resp_err),
        .RegWrite_MEM_WB(RegWrite_MEM_WB),
        .LoadType_MEM_WB(LoadType_MEM_WB),
        .AltSel_MEM_WB(AltSel_MEM_WB),
        .AltData_MEM_WB(AltData_MEM_WB),
        .RegWaddr_MEM_WB(RegWaddr_MEM_WB),
        .ALUResult_MEM_WB(ALUResult_MEM_WB),
        .RegRdata2_MEM_WB(RegRdata2_MEM_WB),
        .PC_MEM_WB(PC_MEM_WB),
        .RegWaddr_WB(RegWaddr_WB),
        .RegWdata_WB(RegWdata_WB),
        .RegWrite_WB(RegWrite_WB),
        .RegWdata_Bypass_WB(RegWdata_Bypass_WB),
        .PC_WB(PC_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Loaded value from the memory word, computed with plain shifts and masks
    function automatic logic [31:0] ref_align(input logic [2:0] lt, input logic [31:0] m,
                                              input logic [31:0] rt, input logic [1:0] va);
        int v;
        int keep;
        logic [31:0] b;
        v = int'(va);
        case (lt)
            3'd2, 3'd3: begin
                b = (m >> (8 * v)) & 32'hFF;
                if (lt == 3'd2 && b >= 32'h80) b = b | 32'hFFFF_FF00;
                return b;
            end
            3'd4, 3'd5: begin
                b = (m >> (16 * (v / 2))) & 32'hFFFF;
                if (lt == 3'd4 && b >= 32'h8000) b = b | 32'hFFFF_0000;
                return b;
            end
            3'd6: begin
                keep = 8 * (3 - v);
                return (m << keep) | (rt & ((32'h1 << keep) - 32'h1));
            end
            3'd7: return (m >> (8 * v)) | (rt & ~(32'hFFFF_FFFF >> (8 * v)));
            default: return m;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_lt = 0; m_alt = 0; m_altd = 0;
        m_wa = 0; m_alu = 0; m_rt = 0; m_pc = 0;
        m_fifo.delete();
        m_out = 0;
        m_err = 0;
    endtask

    task automatic idle();
        mem_to_wb_valid = 0;
        mem_load_issue  = 0;
        data_rvalid     = 0;
        data_rdata      = 32'h0;
        rst             = 0;
    endtask

    task automatic set_instr(input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rt,
                             input bit alt, input logic [31:0] altd, input logic [4:0] wa,
                             input logic [3:0] rw, input logic [31:0] pc);
        mem_to_wb_valid  = 1;
        LoadType_MEM_WB  = lt;
        ALUResult_MEM_WB = alu;
        RegRdata2_MEM_WB = rt;
        AltSel_MEM_WB    = alt;
        AltData_MEM_WB   = altd;
        RegWaddr_MEM_WB  = wa;
        RegWrite_MEM_WB  = rw;
        PC_MEM_WB        = pc;
    endtask

    // Let the combinational outputs settle and compare them against the model
    task automatic settle_check();
        bit is_ld, rdy, fire;
        logic [31:0] res;
        #2;
        is_ld = (m_lt != 0);
        rdy   = !is_ld || (m_fifo.size() > 0);
        fire  = m_valid && rdy;
        chk("wb_stage_valid", 32'(wb_stage_valid), 32'(m_valid));
        chk("wb_allowin", 32'(wb_allowin), 32'(!m_valid || rdy));
        chk("wb_stall", 32'(wb_stall), 32'(m_valid && !rdy));
        chk("load_credit", 32'(load_credit), 32'((m_out + m_fifo.size()) < DEPTH));
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("PC_WB", PC_WB, m_pc);
        if (!(is_ld && m_fifo.size() == 0)) begin
            if (m_alt) res = m_altd;
            else if (is_ld) res = ref_align(m_lt, m_fifo[0], m_rt, m_alu[1:0]);
            else res = m_alu;
            chk("bypass", RegWdata_Bypass_WB, res);
            chk("RegWdata_WB", RegWdata_WB, fire ? res : 32'h0);
        end else begin
            chk("RegWdata_WB_idle", RegWdata_WB, 32'h0);
        end
        chk("RegWrite_WB", 32'(RegWrite_WB), fire ? 32'(m_rw) : 32'h0);
        chk("RegWaddr_WB", 32'(RegWaddr_WB), fire ? 32'(m_wa) : 32'h0);
    endtask

    // Apply the clock edge to the model, then to the DUT
    task automatic advance();
        bit is_ld, rdy, fire, allow, acc, popb;
        int sz;
        if (rst) begin
            model_reset();
        end else begin
            is_ld = (m_lt != 0);
            rdy   = !is_ld || (m_fifo.size() > 0);
            fire  = m_valid && rdy;
            allow = !m_valid || rdy;
            acc   = data_rvalid && (m_out > 0);
            if (data_rvalid && m_out == 0) m_err = 1;
            sz    = m_fifo.size();
            popb  = fire && is_ld;
            if (popb) void'(m_fifo.pop_front());
            if (acc) begin
                if (sz == DEPTH && !popb) m_err = 1;
                else m_fifo.push_back(data_rdata);
            end
            m_out = m_out + int'(mem_load_issue) - int'(acc);
            if (allow) begin
                m_valid = mem_to_wb_valid;
                if (mem_to_wb_valid) begin
                    m_rw = RegWrite_MEM_WB; m_lt = LoadType_MEM_WB; m_alt = AltSel_MEM_WB;
                    m_altd = AltData_MEM_WB; m_wa = RegWaddr_MEM_WB; m_alu = ALUResult_MEM_WB;
                    m_rt = RegRdata2_MEM_WB; m_pc = PC_MEM_WB;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle_check();
        advance();
    endtask

    initial begin
        idle();
        set_instr(3'd0, 32'h0, 32'h0, 0, 32'h0, 5'd0, 4'd0, 32'h0);
        mem_to_wb_valid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        rst = 0;

        // Reset state, checked against fixed constants
        #2;
        chk("rst_allowin", 32'(wb_allowin), 32'h1);
        chk("rst_credit", 32'(load_credit), 32'h1);
        chk("rst_stall", 32'(wb_stall), 32'h0);
        chk("rst_regwrite", 32'(RegWrite_WB), 32'h0);
        chk("rst_pc", PC_WB, 32'h0);
        chk("rst_bypass", RegWdata_Bypass_WB, 32'h0);
        advance();

        // LB at vaddr 2, response queued before the load reaches WB
        idle(); mem_load_issue = 1; cycle();
        idle(); data_rvalid = 1; data_rdata = 32'h1280_3456; cycle();
        idle(); set_instr(3'd2, 32'h1000_0002, 32'h0, 0, 32'h0, 5'd5, 4'hF, 32'h0000_0100); cycle();
        idle(); settle_check();
        chk("lb_data", RegWdata_WB, 32'hFFFF_FF80);
        chk("lb_we", 32'(RegWrite_WB), 32'hF);
        advance();
        idle(); settle_check();
        chk("lb_we_after", 32'(RegWrite_WB), 32'h0);
        advance();

        // LWL and LWR at vaddr 1 with the same memory word and rt
        idle(); mem_load_issue = 1; cycle();
        idle(); data_rvalid = 1; data_rdata = 32'hAABB_CCDD; mem_load_issue = 1; cycle();
        idle(); data_rvalid = 1; data_rdata = 32'hAABB_CCDD;
        set_instr(3'd6, 32'h2000_0001, 32'h1122_3344, 0, 32'h0, 5'd6, 4'hF, 32'h0000_0104); cycle();
        idle(); set_instr(3'd7, 32'h2000_0001, 32'h1122_3344, 0, 32'h0, 5'd7, 4'hF, 32'h0000_0108);
        settle_check();
        chk("lwl_data", RegWdata_WB, 32'hCCDD_3344);
        advance();
        idle(); settle_check();
        chk("lwr_data", RegWdata_WB, 32'h11AA_BBCC);
        advance();

        // LW waits three cycles for its response; an ADD queued behind it is held
        idle(); mem_load_issue = 1;
        set_instr(3'd1, 32'h3000_0000, 32'h0, 0, 32'h0, 5'd8, 4'hF, 32'h0000_0200); cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            set_instr(3'd0, 32'h0000_0ADD, 32'h0, 0, 32'h0, 5'd9, 4'hF, 32'h0000_0204);
            if (i == 2) begin data_rvalid = 1; data_rdata = 32'hCAFE_F00D; end
            settle_check();
            chk("delay_stall", 32'(wb_stall), 32'h1);
            chk("delay_allowin", 32'(wb_allowin), 32'h0);
            advance();
        end
        idle(); set_instr(3'd0, 32'h0000_0ADD, 32'h0, 0, 32'h0, 5'd9, 4'hF, 32'h0000_0204);
        settle_check();
        chk("delay_wdata", RegWdata_WB, 32'hCAFE_F00D);
        chk("delay_waddr", 32'(RegWaddr_WB), 32'd8);
        advance();
        idle(); settle_check();
        chk("add_wdata", RegWdata_WB, 32'h0000_0ADD);
        advance();

        // Credit exhaustion, then a response and a pop in the same cycle
        idle(); mem_load_issue = 1; cycle();
        idle(); mem_load_issue = 1; cycle();
        idle(); settle_check();
        chk("credit_zero", 32'(load_credit), 32'h0);
        advance();
        idle(); data_rvalid = 1; data_rdata = 32'h0000_1111;
        set_instr(3'd1, 32'h4000_0000, 32'h0, 0, 32'h0, 5'd10, 4'hF, 32'h0000_0300); cycle();
        idle(); data_rvalid = 1; data_rdata = 32'h0000_2222;
        set_instr(3'd1, 32'h4000_0004, 32'h0, 0, 32'h0, 5'd11, 4'hF, 32'h0000_0304); cycle();
        idle(); settle_check();
        chk("credit_back", 32'(load_credit), 32'h1);
        chk("second_lw", RegWdata_WB, 32'h0000_2222);
        advance();

        // Response with nothing outstanding is flagged and the flag sticks
        idle(); data_rvalid = 1; data_rdata = 32'hDEAD_BEEF; cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); settle_check();
            chk("err_sticky", 32'(resp_err), 32'h1);
            advance();
        end
        idle(); set_instr(3'd1, 32'h5000_0000, 32'h0, 0, 32'h0, 5'd12, 4'hF, 32'h0000_0400); cycle();
        idle(); settle_check();
        chk("err_fifo_empty_stall", 32'(wb_stall), 32'h1);
        advance();

        // Reset with a stalled load, one queued response and one outstanding load
        idle(); rst = 1; cycle();
        idle(); mem_load_issue = 1; cycle();
        idle(); mem_load_issue = 1; cycle();
        idle(); data_rvalid = 1; data_rdata = 32'h0000_3333; cycle();
        idle(); rst = 1;
        set_instr(3'd1, 32'h6000_0000, 32'h0, 0, 32'h0, 5'd13, 4'hF, 32'h0000_0500); cycle();
        idle(); settle_check();
        chk("rst_mid_valid", 32'(wb_stage_valid), 32'h0);
        chk("rst_mid_credit", 32'(load_credit), 32'h1);
        chk("rst_mid_err", 32'(resp_err), 32'h0);
        advance();
        idle(); set_instr(3'd1, 32'h6000_0000, 32'h0, 0, 32'h0, 5'd13, 4'hF, 32'h0000_0500); cycle();
        idle(); settle_check();
        chk("rst_mid_fifo_empty", 32'(wb_stall), 32'h1);
        advance();
        idle(); rst = 1; cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit stalled_dry;
            idle();
            set_instr(3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom_range(0, 3) == 0),
                      $urandom, 5'($urandom), 4'($urandom), $urandom);
            mem_to_wb_valid = ($urandom_range(0, 1) == 1);
            stalled_dry = m_valid && (m_lt != 0) && (m_fifo.size() == 0) && (m_out == 0);
            if ((m_out + m_fifo.size()) < DEPTH)
                mem_load_issue = stalled_dry || ($urandom_range(0, 1) == 1);
            if (m_out > 0) begin
                data_rvalid = ($urandom_range(0, 2) != 0);
                data_rdata  = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
